srr_chain_table: RTL and testbench
==================================

# srr_chain_table

Parametrised successor to the SRR table. It allocates Same-Row-Request entries from a free list and retires them individually instead of only by bulk clear. Each insert performs a single-cycle lookup-and-append, and a row chain is split across linked entries once it reaches MAX_CHAIN. It sits between the request classifier, which inserts every arriving request, and the row-hit scheduler, which pops the serviced request heads.

## Interface
- ENTRIES, default `MAX_SRR_ENTRIES` (16): number of table entries, power of two, ≥2.
- TAG_W, default `HIT_TAG_WIDTH`: width of the {bank_group, bank, row} tag.
- REQ_W, default `REQUEST_ID_WIDTH`: width of a request ID.
- MAX_CHAIN, default 8: maximum number of requests per entry, ≥1.
- ID_W, derived as $clog2(ENTRIES); CNT_W, derived as $clog2(MAX_CHAIN+1).
- clk  in  1  the single clock.
- rst_n  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous flush of all entries.
- ins_valid  in  1  insert request.
- ins_ready  out  1  asserted when the free list is non-empty, rst_n is high and clear is low.
- ins_tag  in  TAG_W  row tag of the inserted request.
- ins_req  in  REQ_W  request ID.
- ins_done  out  1  one-cycle pulse, one cycle after an accepted insert.
- ins_id  out  ID_W  entry the request landed in.
- ins_new  out  1  the entry was freshly allocated.
- ins_linked  out  1  the fresh entry was linked behind a saturated predecessor.
- pop_valid  in  1  retire the head request of an entry.
- pop_id  in  ID_W  entry to pop.
- pop_next_head  in  REQ_W  new head request ID, supplied by the request store.
- pop_done  out  1  one-cycle pulse, one cycle after a pop.
- pop_err  out  1  one-cycle pulse, one cycle after a pop to an invalid entry.
- pop_freed  out  1  the pop emptied and freed the entry.
- pop_succ_valid  out  1  the freed entry had a chain successor.
- pop_succ_id  out  ID_W  ID of that successor.
- rd_addr  in  ID_W  read index.
- rd_valid, rd_tag, rd_count, rd_head, rd_tail, rd_next, rd_next_valid  out  1/TAG_W/CNT_W/REQ_W/REQ_W/ID_W/1  registered read of the entry at rd_addr.
- num_entries  out  ID_W+1  number of valid entries.
- empty  out  1  num_entries == 0.

## Operation
- Per-entry state: valid, tag, count, head, tail, next, next_valid.
- CAM match condition: valid && tag == ins_tag && !next_valid. At most one entry can match, namely the tail of that row's chain.
- An insert is accepted when ins_valid && ins_ready.
- Insert on a hit with count < MAX_CHAIN: count += 1, tail = ins_req. ins_new = 0.
- Insert on a hit with count == MAX_CHAIN: allocate entry F from the free list. Set F.tag = ins_tag, F.count = 1, F.head = F.tail = ins_req. Set the hit entry's next = F and next_valid = 1. ins_new = 1, ins_linked = 1.
- Insert on a miss: allocate F as above. ins_new = 1, ins_linked = 0.
- Pop on a valid entry: count -= 1, head = pop_next_head.
  - If the new count is 0: clear valid and next_valid, push the ID onto the free list, and assert pop_freed.
  - If the entry had next_valid: also assert pop_succ_valid and pop_succ_id = next.
- Pop on an invalid entry: no state change, pop_err = 1, pop_done = 1.
- Insert and pop in the same cycle:
  - The CAM evaluates pre-pop state.
  - When both target the same entry, the resulting count is count + 1 − 1.
  - If that entry had count 1 and the insert appends to it, the entry stays valid with head = tail = ins_req and is not freed.
  - A simultaneous free-list push and pop is legal.
- clear: invalidate all entries, reload the free list with 0..ENTRIES−1, and drop any concurrent insert or pop (no done pulses).
- Reset values:
  - Every output is 0 during reset.
  - ins_ready and empty are 1 from the first cycle after rst_n rises.
  - The free list holds 0..ENTRIES−1 in ascending order.
  - All entries are invalid with fields zeroed.

## Timing
- Table update occurs on the accepting edge. A back-to-back insert with the same tag sees the prior append, so there are no bubbles.
- ins_done, ins_id, ins_new, ins_linked: 1-cycle latency, registered.
- pop_* outputs: 1-cycle latency.
- rd_*: 1-cycle latency, reflecting state after the edge on which rd_addr was sampled.
- num_entries and empty are registered and update on the same edge as the table.
- The free list is FIFO order. Freed IDs are reused after all currently free IDs.

## Structure
- The shared header `dram_scheduler_types.vh` holds the existing `MAX_SRR_ENTRIES`, `HIT_TAG_WIDTH` and `REQUEST_ID_WIDTH`, plus a new `SRR_MAX_CHAIN` (default 8).
- Sub-module srr_free_list: a FIFO of ENTRIES × ID_W.
  - Synchronous reset and clear both reload it with ascending IDs.
  - Ports: push, push_id, pop, pop_id, empty, count.
- The CAM priority encoder stays inline.

## Test plan
- Reset, then read every entry. Expect rd_valid = 0, ins_ready = 1, empty = 1, and allocation order 0, 1, 2.
- Insert tag 0x12 with req 1, 2, 3 on consecutive cycles. Expect entry 0 with count 3, head 1, tail 3, and ins_new = 1, 0, 0.
- With MAX_CHAIN = 8, insert 9 requests with tag 0x5. Expect the 9th to give ins_id = 1, ins_linked = 1, and entry 0 to read next = 1, next_valid = 1.
- Continue from the previous case: pop entry 0 eight times. Expect the last pop to give pop_freed = 1, pop_succ_valid = 1, pop_succ_id = 1. Entry 0 is then reused only after IDs 2..15.
- Fill all 16 entries with distinct tags. Expect ins_ready = 0. Then pop an entry with count 1 together with an insert of a held tag. Expect the insert to stall one cycle, then allocate the freed ID.
- Same-cycle pop and append to an entry with count 1. Expect count = 1, valid = 1, head = tail = new req, and pop_freed = 0. Separately, pop an invalid entry: expect pop_err = 1.

Source files
------------

// File: rtl/srr_chain_table_pkg.sv
// Shared types and default sizing for the chained Same-Row-Request table.
package srr_chain_table_pkg;

    // Default geometry of the SRR table and the request identifiers it holds.
    localparam int MAX_SRR_ENTRIES  = 16;
    // {bank_group(2), bank(2), row(16)}
    localparam int HIT_TAG_WIDTH    = 20;
    localparam int REQUEST_ID_WIDTH = 8;
    localparam int SRR_MAX_CHAIN    = 8;

    // What an accepted insert does to the table.
    typedef enum logic [1:0] {
        INS_NONE,
        INS_APPEND,
        INS_ALLOC,
        INS_LINK
    } ins_kind_e;

endpackage

// File: rtl/srr_chain_table_free_list.sv
// Circular FIFO of free entry IDs. Reset and clear both refill it with 0..ENTRIES-1.
module srr_free_list
    import srr_chain_table_pkg::*;
#(
    parameter int ENTRIES = MAX_SRR_ENTRIES,
    parameter int ID_W    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] pop_id,
    output logic            empty,
    output logic [ID_W:0]   count
);

    logic [ID_W-1:0] mem [ENTRIES];
    logic [ID_W-1:0] rd_ptr;
    logic [ID_W-1:0] wr_ptr;

    assign pop_id = mem[rd_ptr];
    assign empty  = (count == '0);

    // Ring storage: reload ascending IDs on reset/clear, otherwise push at the tail and pop at the head.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= ID_W'(i);
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= (ID_W+1)'(ENTRIES);
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/srr_chain_table.sv
// Same-Row-Request table with per-entry retirement and row chains split across linked entries.
module srr_chain_table
    import srr_chain_table_pkg::*;
#(
    parameter int  ENTRIES   = MAX_SRR_ENTRIES,
    parameter int  TAG_W     = HIT_TAG_WIDTH,
    parameter int  REQ_W     = REQUEST_ID_WIDTH,
    parameter int  MAX_CHAIN = SRR_MAX_CHAIN,
    localparam int ID_W      = $clog2(ENTRIES),
    localparam int CNT_W     = $clog2(MAX_CHAIN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [TAG_W-1:0] ins_tag,
    input  logic [REQ_W-1:0] ins_req,
    output logic             ins_done,
    output logic [ID_W-1:0]  ins_id,
    output logic             ins_new,
    output logic             ins_linked,
    input  logic             pop_valid,
    input  logic [ID_W-1:0]  pop_id,
    input  logic [REQ_W-1:0] pop_next_head,
    output logic             pop_done,
    output logic             pop_err,
    output logic             pop_freed,
    output logic             pop_succ_valid,
    output logic [ID_W-1:0]  pop_succ_id,
    input  logic [ID_W-1:0]  rd_addr,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [CNT_W-1:0] rd_count,
    output logic [REQ_W-1:0] rd_head,
    output logic [REQ_W-1:0] rd_tail,
    output logic [ID_W-1:0]  rd_next,
    output logic             rd_next_valid,
    output logic [ID_W:0]    num_entries,
    output logic             empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_CHAIN);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic             ent_valid      [ENTRIES];
    logic [TAG_W-1:0] ent_tag        [ENTRIES];
    logic [CNT_W-1:0] ent_count      [ENTRIES];
    logic [REQ_W-1:0] ent_head       [ENTRIES];
    logic [REQ_W-1:0] ent_tail       [ENTRIES];
    logic [ID_W-1:0]  ent_next       [ENTRIES];
    logic             ent_next_valid [ENTRIES];

    logic             ent_valid_d      [ENTRIES];
    logic [TAG_W-1:0] ent_tag_d        [ENTRIES];
    logic [CNT_W-1:0] ent_count_d      [ENTRIES];
    logic [REQ_W-1:0] ent_head_d       [ENTRIES];
    logic [REQ_W-1:0] ent_tail_d       [ENTRIES];
    logic [ID_W-1:0]  ent_next_d       [ENTRIES];
    logic             ent_next_valid_d [ENTRIES];

    logic            fl_push;
    logic            fl_pop;
    logic [ID_W-1:0] fl_pop_id;
    logic            fl_empty;
    logic [ID_W:0]   fl_count;

    logic            hit;
    logic [ID_W-1:0] hit_idx;
    ins_kind_e       ins_kind;
    logic            ins_acc;
    logic            alloc_any;
    logic            pop_act;
    logic            pop_ok;
    logic            pop_bad;
    logic            same_app;
    logic            link_same;
    logic            freed;
    logic            succ_valid;
    logic [ID_W-1:0] succ_id;
    logic [ID_W:0]   num_d;

    assign ins_ready   = rst_n && !clear && !fl_empty;
    assign ins_acc     = ins_valid && ins_ready;
    assign num_entries = (ID_W+1)'(ENTRIES) - fl_count;

    srr_free_list #(
        .ENTRIES (ENTRIES),
        .ID_W    (ID_W)
    ) u_free_list (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .push    (fl_push),
        .push_id (pop_id),
        .pop     (fl_pop),
        .pop_id  (fl_pop_id),
        .empty   (fl_empty),
        .count   (fl_count)
    );

    // CAM lookup: only the open tail of a row chain can match, so the encoder just picks it out.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_tag[i] == ins_tag) && !ent_next_valid[i]) begin
                hit     = 1'b1;
                hit_idx = ID_W'(i);
            end
        end
    end

    // Classify the insert and pop against pre-update state and work out frees and successors.
    always_comb begin
        ins_kind = INS_NONE;
        if (ins_acc) begin
            if (!hit) begin
                ins_kind = INS_ALLOC;
            end else if (ent_count[hit_idx] == FULL_CNT) begin
                ins_kind = INS_LINK;
            end else begin
                ins_kind = INS_APPEND;
            end
        end
        alloc_any  = (ins_kind == INS_ALLOC) || (ins_kind == INS_LINK);
        pop_act    = pop_valid && !clear;
        pop_ok     = pop_act && ent_valid[pop_id];
        pop_bad    = pop_act && !ent_valid[pop_id];
        same_app   = pop_ok && (ins_kind == INS_APPEND) && (hit_idx == pop_id);
        link_same  = (ins_kind == INS_LINK) && (hit_idx == pop_id);
        freed      = pop_ok && (ent_count[pop_id] == ONE_CNT) && !same_app;
        succ_valid = freed && (ent_next_valid[pop_id] || link_same);
        succ_id    = ent_next_valid[pop_id] ? ent_next[pop_id] : fl_pop_id;
        fl_pop     = alloc_any;
        fl_push    = freed;
    end

    // Next table state: pop first, then the insert, then release an entry that drained to zero.
    always_comb begin
        ent_valid_d      = ent_valid;
        ent_tag_d        = ent_tag;
        ent_count_d      = ent_count;
        ent_head_d       = ent_head;
        ent_tail_d       = ent_tail;
        ent_next_d       = ent_next;
        ent_next_valid_d = ent_next_valid;
        if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid_d[i]      = 1'b0;
                ent_tag_d[i]        = '0;
                ent_count_d[i]      = '0;
                ent_head_d[i]       = '0;
                ent_tail_d[i]       = '0;
                ent_next_d[i]       = '0;
                ent_next_valid_d[i] = 1'b0;
            end
        end else begin
            if (pop_ok) begin
                ent_count_d[pop_id] = ent_count[pop_id] - ONE_CNT;
                ent_head_d[pop_id]  = pop_next_head;
            end
            case (ins_kind)
                INS_APPEND: begin
                    ent_count_d[hit_idx] = same_app ? ent_count[hit_idx] : ent_count[hit_idx] + ONE_CNT;
                    ent_tail_d[hit_idx]  = ins_req;
                    if (same_app && (ent_count[hit_idx] == ONE_CNT)) begin
                        ent_head_d[hit_idx] = ins_req;
                    end
                end
                INS_ALLOC, INS_LINK: begin
                    ent_valid_d[fl_pop_id]      = 1'b1;
                    ent_tag_d[fl_pop_id]        = ins_tag;
                    ent_count_d[fl_pop_id]      = ONE_CNT;
                    ent_head_d[fl_pop_id]       = ins_req;
                    ent_tail_d[fl_pop_id]       = ins_req;
                    ent_next_d[fl_pop_id]       = '0;
                    ent_next_valid_d[fl_pop_id] = 1'b0;
                    if (ins_kind == INS_LINK) begin
                        ent_next_d[hit_idx]       = fl_pop_id;
                        ent_next_valid_d[hit_idx] = 1'b1;
                    end
                end
                default: ;
            endcase
            if (freed) begin
                ent_valid_d[pop_id]      = 1'b0;
                ent_next_valid_d[pop_id] = 1'b0;
            end
        end
    end

    // Occupancy after this edge, used for the registered empty flag.
    always_comb begin
        num_d = num_entries;
        if (clear) begin
            num_d = '0;
        end else begin
            if (alloc_any) begin
                num_d = num_d + 1'b1;
            end
            if (freed) begin
                num_d = num_d - 1'b1;
            end
        end
    end

    // Table registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid[i]      <= 1'b0;
                ent_tag[i]        <= '0;
                ent_count[i]      <= '0;
                ent_head[i]       <= '0;
                ent_tail[i]       <= '0;
                ent_next[i]       <= '0;
                ent_next_valid[i] <= 1'b0;
            end
        end else begin
            ent_valid      <= ent_valid_d;
            ent_tag        <= ent_tag_d;
            ent_count      <= ent_count_d;
            ent_head       <= ent_head_d;
            ent_tail       <= ent_tail_d;
            ent_next       <= ent_next_d;
            ent_next_valid <= ent_next_valid_d;
        end
    end

    // Registered responses; the read port shows the entry as it stands after this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ins_done       <= 1'b0;
            ins_id         <= '0;
            ins_new        <= 1'b0;
            ins_linked     <= 1'b0;
            pop_done       <= 1'b0;
            pop_err        <= 1'b0;
            pop_freed      <= 1'b0;
            pop_succ_valid <= 1'b0;
            pop_succ_id    <= '0;
            rd_valid       <= 1'b0;
            rd_tag         <= '0;
            rd_count       <= '0;
            rd_head        <= '0;
            rd_tail        <= '0;
            rd_next        <= '0;
            rd_next_valid  <= 1'b0;
            empty          <= 1'b0;
        end else begin
            ins_done       <= (ins_kind != INS_NONE);
            ins_id         <= (ins_kind == INS_APPEND) ? hit_idx : (alloc_any ? fl_pop_id : '0);
            ins_new        <= alloc_any;
            ins_linked     <= (ins_kind == INS_LINK);
            pop_done       <= pop_act;
            pop_err        <= pop_bad;
            pop_freed      <= freed;
            pop_succ_valid <= succ_valid;
            pop_succ_id    <= succ_valid ? succ_id : '0;
            rd_valid       <= ent_valid_d[rd_addr];
            rd_tag         <= ent_tag_d[rd_addr];
            rd_count       <= ent_count_d[rd_addr];
            rd_head        <= ent_head_d[rd_addr];
            rd_tail        <= ent_tail_d[rd_addr];
            rd_next        <= ent_next_d[rd_addr];
            rd_next_valid  <= ent_next_valid_d[rd_addr];
            empty          <= (num_d == '0);
        end
    end

endmodule

// File: tb/tb_srr_chain_table.sv
// Scoreboard bench for srr_chain_table: a queue-based reference model predicts every response.
module tb_srr_chain_table;
    import srr_chain_table_pkg::*;

    localparam int ENTRIES   = 16;
    localparam int TAG_W     = HIT_TAG_WIDTH;
    localparam int REQ_W     = REQUEST_ID_WIDTH;
    localparam int MAX_CHAIN = 8;
    localparam int ID_W      = $clog2(ENTRIES);
    localparam int CNT_W     = $clog2(MAX_CHAIN + 1);

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             ins_valid;
    logic             ins_ready;
    logic [TAG_W-1:0] ins_tag;
    logic [REQ_W-1:0] ins_req;
    logic             ins_done;
    logic [ID_W-1:0]  ins_id;
    logic             ins_new;
    logic             ins_linked;
    logic             pop_valid;
    logic [ID_W-1:0]  pop_id;
    logic [REQ_W-1:0] pop_next_head;
    logic             pop_done;
    logic             pop_err;
    logic             pop_freed;
    logic             pop_succ_valid;
    logic [ID_W-1:0]  pop_succ_id;
    logic [ID_W-1:0]  rd_addr;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [CNT_W-1:0] rd_count;
    logic [REQ_W-1:0] rd_head;
    logic [REQ_W-1:0] rd_tail;
    logic [ID_W-1:0]  rd_next;
    logic             rd_next_valid;
    logic [ID_W:0]    num_entries;
    logic             empty;

    srr_chain_table #(
        .ENTRIES   (ENTRIES),
        .TAG_W     (TAG_W),
        .REQ_W     (REQ_W),
        .MAX_CHAIN (MAX_CHAIN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_tag        (ins_tag),
        .ins_req        (ins_req),
        .ins_done       (ins_done),
        .ins_id         (ins_id),
        .ins_new        (ins_new),
        .ins_linked     (ins_linked),
        .pop_valid      (pop_valid),
        .pop_id         (pop_id),
        .pop_next_head  (pop_next_head),
        .pop_done       (pop_done),
        .pop_err        (pop_err),
        .pop_freed      (pop_freed),
        .pop_succ_valid (pop_succ_valid),
        .pop_succ_id    (pop_succ_id),
        .rd_addr        (rd_addr),
        .rd_valid       (rd_valid),
        .rd_tag         (rd_tag),
        .rd_count       (rd_count),
        .rd_head        (rd_head),
        .rd_tail        (rd_tail),
        .rd_next        (rd_next),
        .rd_next_valid  (rd_next_valid),
        .num_entries    (num_entries),
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            is_new;
        logic            linked;
    } ins_exp_t;

    typedef struct packed {
        logic            err;
        logic            freed;
        logic            succ_valid;
        logic [ID_W-1:0] succ_id;
    } pop_exp_t;

    typedef struct packed {
        logic             valid;
        logic             clean;
        logic [TAG_W-1:0] tag;
        logic [CNT_W-1:0] count;
        logic [REQ_W-1:0] head;
        logic [REQ_W-1:0] tail;
        logic [ID_W-1:0]  next;
        logic             next_valid;
        logic [ID_W:0]    num;
    } rd_exp_t;

    ins_exp_t ins_q[$];
    pop_exp_t pop_q[$];
    rd_exp_t  rd_q[$];

    // Reference model: each entry holds its requests as a queue; the free list is a plain queue.
    bit               m_valid      [ENTRIES];
    bit               m_clean      [ENTRIES];
    logic [TAG_W-1:0] m_tag        [ENTRIES];
    logic [REQ_W-1:0] m_reqs       [ENTRIES][$];
    int               m_next       [ENTRIES];
    bit               m_next_valid [ENTRIES];
    int               m_free[$];

    int n_vec  = 0;
    int n_miss = 0;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]      = 1'b0;
            m_clean[i]      = 1'b1;
            m_tag[i]        = '0;
            m_reqs[i].delete();
            m_next[i]       = 0;
            m_next_valid[i] = 1'b0;
        end
        m_free.delete();
        for (int i = 0; i < ENTRIES; i++) m_free.push_back(i);
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < ENTRIES; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the model and queue the expected responses.
    task automatic applyStimulus(input bit iv, input logic [TAG_W-1:0] tag, input logic [REQ_W-1:0] req,
                                 input bit pv, input logic [ID_W-1:0] pid, input bit clr,
                                 input int rd_a, output bit accepted);
        int       hit;
        int       f;
        int       pre_cnt;
        int       ra;
        bit       acc;
        bit       pop_ok;
        bit       exp_ready;
        logic [REQ_W-1:0] nh;
        ins_exp_t ie;
        pop_exp_t pe;
        rd_exp_t  re;
        @(negedge clk);
        nh = REQ_W'($urandom);
        if (pv && m_valid[pid] && m_reqs[pid].size() > 1) nh = m_reqs[pid][1];
        ra = (rd_a < 0) ? int'($urandom_range(ENTRIES - 1, 0)) : rd_a;
        clear         = clr;
        ins_valid     = iv;
        ins_tag       = tag;
        ins_req       = req;
        pop_valid     = pv;
        pop_id        = pid;
        pop_next_head = nh;
        rd_addr       = ID_W'(ra);
        exp_ready = !clr && (m_free.size() > 0);
        acc       = iv && exp_ready;
        if (clr) begin
            model_reset();
        end else begin
            hit = -1;
            for (int i = 0; i < ENTRIES; i++)
                if (m_valid[i] && m_tag[i] == tag && !m_next_valid[i]) hit = i;
            pre_cnt = (hit >= 0) ? m_reqs[hit].size() : 0;
            pop_ok  = pv && m_valid[pid];
            if (pv && !pop_ok) begin
                pe.err = 1'b1; pe.freed = 1'b0; pe.succ_valid = 1'b0; pe.succ_id = '0;
                pop_q.push_back(pe);
            end
            if (pop_ok) void'(m_reqs[pid].pop_front());
            if (acc) begin
                if (hit >= 0 && pre_cnt < MAX_CHAIN) begin
                    m_reqs[hit].push_back(req);
                    ie.id = ID_W'(hit); ie.is_new = 1'b0; ie.linked = 1'b0;
                end else begin
                    f = m_free.pop_front();
                    m_valid[f]      = 1'b1;
                    m_clean[f]      = 1'b0;
                    m_tag[f]        = tag;
                    m_reqs[f].delete();
                    m_reqs[f].push_back(req);
                    m_next[f]       = 0;
                    m_next_valid[f] = 1'b0;
                    if (hit >= 0) begin
                        m_next[hit]       = f;
                        m_next_valid[hit] = 1'b1;
                    end
                    ie.id = ID_W'(f); ie.is_new = 1'b1; ie.linked = (hit >= 0);
                end
                ins_q.push_back(ie);
            end
            if (pop_ok) begin
                pe.err        = 1'b0;
                pe.freed      = (m_reqs[pid].size() == 0);
                pe.succ_valid = pe.freed && m_next_valid[pid];
                pe.succ_id    = pe.succ_valid ? ID_W'(m_next[pid]) : '0;
                if (pe.freed) begin
                    m_valid[pid]      = 1'b0;
                    m_next_valid[pid] = 1'b0;
                    m_free.push_back(int'(pid));
                end
                pop_q.push_back(pe);
            end
        end
        re.valid      = m_valid[ra];
        re.clean      = m_clean[ra];
        re.tag        = m_tag[ra];
        re.count      = CNT_W'(m_reqs[ra].size());
        re.head       = (m_reqs[ra].size() > 0) ? m_reqs[ra][0] : '0;
        re.tail       = (m_reqs[ra].size() > 0) ? m_reqs[ra][$] : '0;
        re.next       = ID_W'(m_next[ra]);
        re.next_valid = m_next_valid[ra];
        re.num        = (ID_W+1)'(model_count());
        rd_q.push_back(re);
        #1;
        checkOutput("ins_ready", 64'(ins_ready), 64'(exp_ready));
        accepted = acc;
    endtask

    // Monitor: after each active edge, retire whatever the DUT presents against the queued expectations.
    initial begin
        ins_exp_t ie;
        pop_exp_t pe;
        rd_exp_t  re;
        forever begin
            @(posedge clk);
            #1;
            if (ins_q.size() > 0) begin
                ie = ins_q.pop_front();
                checkOutput("ins_done", 64'(ins_done), 64'd1);
                checkOutput("ins_id", 64'(ins_id), 64'(ie.id));
                checkOutput("ins_new", 64'(ins_new), 64'(ie.is_new));
                checkOutput("ins_linked", 64'(ins_linked), 64'(ie.linked));
            end else if (ins_done) begin
                checkOutput("ins_done_spurious", 64'(ins_done), 64'd0);
            end
            if (pop_q.size() > 0) begin
                pe = pop_q.pop_front();
                checkOutput("pop_done", 64'(pop_done), 64'd1);
                checkOutput("pop_err", 64'(pop_err), 64'(pe.err));
                checkOutput("pop_freed", 64'(pop_freed), 64'(pe.freed));
                checkOutput("pop_succ_valid", 64'(pop_succ_valid), 64'(pe.succ_valid));
                if (pe.succ_valid) checkOutput("pop_succ_id", 64'(pop_succ_id), 64'(pe.succ_id));
            end else if (pop_done) begin
                checkOutput("pop_done_spurious", 64'(pop_done), 64'd0);
            end
            if (rd_q.size() > 0) begin
                re = rd_q.pop_front();
                checkOutput("rd_valid", 64'(rd_valid), 64'(re.valid));
                if (re.valid || re.clean) begin
                    checkOutput("rd_tag", 64'(rd_tag), 64'(re.tag));
                    checkOutput("rd_count", 64'(rd_count), 64'(re.count));
                    checkOutput("rd_head", 64'(rd_head), 64'(re.head));
                    checkOutput("rd_tail", 64'(rd_tail), 64'(re.tail));
                    checkOutput("rd_next_valid", 64'(rd_next_valid), 64'(re.next_valid));
                    if (re.next_valid || re.clean) checkOutput("rd_next", 64'(rd_next), 64'(re.next));
                end
                checkOutput("num_entries", 64'(num_entries), 64'(re.num));
                checkOutput("empty", 64'(empty), 64'(re.num == '0));
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        bit acc;
        int tries;
        int vl[$];
        bit iv, pv, clr;
        logic [ID_W-1:0] pid;

        rst_n = 1'b0; clear = 1'b0; ins_valid = 1'b1; ins_tag = '0; ins_req = '0;
        pop_valid = 1'b1; pop_id = '0; pop_next_head = '0; rd_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checkOutput("reset_ins_ready", 64'(ins_ready), 64'd0);
        checkOutput("reset_empty", 64'(empty), 64'd0);
        checkOutput("reset_ins_done", 64'(ins_done), 64'd0);
        checkOutput("reset_pop_done", 64'(pop_done), 64'd0);
        checkOutput("reset_num_entries", 64'(num_entries), 64'd0);
        checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
        ins_valid = 1'b0; pop_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_empty", 64'(empty), 64'd1);
        checkOutput("post_reset_ins_ready", 64'(ins_ready), 64'd1);

        $display("[TB] reading every entry after reset");
        for (int i = 0; i < ENTRIES; i++) applyStimulus(0, '0, '0, 0, '0, 0, i, acc);

        $display("[TB] allocation order");
        for (int i = 0; i < 3; i++) applyStimulus(1, TAG_W'(32'h100 + i), REQ_W'(i), 0, '0, 0, i, acc);

        $display("[TB] same-row append");
        applyStimulus(0, '0, '0, 0, '0, 1, 0, acc);
        for (int r = 1; r <= 3; r++) applyStimulus(1, TAG_W'(32'h12), REQ_W'(r), 0, '0, 0, 0, acc);

        $display("[TB] chain saturation and link");
        applyStimulus(0, '0, '0, 0, '0, 1, 0, acc);
        for (int k = 0; k < 9; k++) applyStimulus(1, TAG_W'(32'h5), REQ_W'(10 + k), 0, '0, 0, 0, acc);

        $display("[TB] draining entry 0 and reuse order");
        for (int k = 0; k < 8; k++) applyStimulus(0, '0, '0, 1, '0, 0, 0, acc);
        for (int k = 0; k < 15; k++) applyStimulus(1, TAG_W'(32'h200 + k), REQ_W'(40 + k), 0, '0, 0, -1, acc);

        $display("[TB] full table stall");
        applyStimulus(1, TAG_W'(32'h200), REQ_W'(8'h77), 1, ID_W'(2), 0, 2, acc);
        tries = 0;
        while (!acc && tries < 4) begin
            applyStimulus(1, TAG_W'(32'h200), REQ_W'(8'h77), 0, '0, 0, 2, acc);
            tries++;
        end

        $display("[TB] same-cycle pop and append, invalid pop");
        applyStimulus(0, '0, '0, 1, ID_W'(3), 0, 3, acc);
        applyStimulus(1, TAG_W'(32'h200), REQ_W'(8'h88), 1, ID_W'(2), 0, 2, acc);
        applyStimulus(0, '0, '0, 1, ID_W'(3), 0, 2, acc);

        $display("[TB] randomized traffic");
        applyStimulus(0, '0, '0, 0, '0, 1, -1, acc);
        for (int n = 0; n < 700; n++) begin
            iv  = ($urandom_range(3, 0) != 0);
            pv  = (n < 350) ? ($urandom_range(3, 0) == 0) : ($urandom_range(1, 0) == 1);
            clr = ($urandom_range(249, 0) == 0);
            vl.delete();
            for (int i = 0; i < ENTRIES; i++) if (m_valid[i]) vl.push_back(i);
            if (vl.size() > 0 && $urandom_range(9, 0) != 0)
                pid = ID_W'(vl[$urandom_range(vl.size() - 1, 0)]);
            else
                pid = ID_W'($urandom_range(ENTRIES - 1, 0));
            applyStimulus(iv, TAG_W'($urandom_range(9, 0)), REQ_W'($urandom), pv, pid, clr, -1, acc);
        end

        for (int k = 0; k < 3; k++) applyStimulus(0, '0, '0, 0, '0, 0, -1, acc);
        repeat (2) @(negedge clk);
        if (ins_q.size() != 0) checkOutput("ins_outstanding", 64'(ins_q.size()), 64'd0);
        if (pop_q.size() != 0) checkOutput("pop_outstanding", 64'(pop_q.size()), 64'd0);
        if (rd_q.size() != 0) checkOutput("rd_outstanding", 64'(rd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
